imem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency instruction memory between two requesters. Requester F is the fetch stage (read-only). Requester L is the program loader/debug port (read/write).
- One transaction outstanding at a time.
- Fixed priority to F, with an anti-starvation override for L.
- Supports flushing in-flight fetch responses on a branch redirect.
- Sits between the IF stage and the imem macro.

---
 rtl/imem_arb_pkg.sv | 20 ++
 rtl/imem_arb_starve_ctr.sv | 40 ++++
 rtl/imem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package imem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_L = 1'b1
   } arb_owner_e;

   // Canonical RISC-V no-op (addi x0,x0,0); handy filler for unused imem words.
   localparam logic [31:0] NOP = 32'h00000013;

   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Starvation counter for the loader port: counts fetch grants that overtake a
// waiting loader and raises force_l once the limit is reached.
module imem_arb_starve_ctr #(
   parameter int STARVE_MAX = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic l_req,
   input  logic f_gnt,
   input  logic l_gnt,
   output logic force_l
);

   localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

   logic [7:0] starve_cnt_q;
   logic [7:0] starve_cnt_d;

   // Clear whenever the loader is served or stops asking; saturate at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!l_req || l_gnt) begin
         starve_cnt_d = 8'd0;
      end else if (f_gnt && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_q <= 8'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign force_l = (starve_cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates one fixed-latency single-port imem between the fetch stage (F)
// and the loader/debug port (L). One access in flight; F has priority unless
// L has been starved. Optional macro IMEM_ARB_PERF_EN adds grant/wait counters.
//
// state | meaning
// IDLE  | no access in flight; a grant may issue
// BUSY  | access in flight; lat_cnt counts down to the response cycle (0),
//       | where the response is returned and a new grant may issue
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic              f_flush,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-3:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
`ifdef IMEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_f_gnt,
   output logic [31:0]       perf_l_gnt,
   output logic [31:0]       perf_l_wait
`endif
);

   // Remaining cycles until the response; loaded at grant, response at zero.
   localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

   arb_state_e state_q, state_d;
   arb_owner_e owner_q, owner_d;
   logic       we_q, we_d;
   logic       flushed_q, flushed_d;
   logic [2:0] lat_cnt_q, lat_cnt_d;

   logic force_l;
   logic resp_cyc;
   logic gnt_ok;
   logic f_cand;
   logic f_win;
   logic l_win;
   logic unused_addr_lsb;

   assign unused_addr_lsb = ^{f_addr[1:0], l_addr[1:0]};

   imem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .l_req   (l_req),
      .f_gnt   (f_win),
      .l_gnt   (l_win),
      .force_l (force_l)
   );

   // Grant decision: only when the port is free or freeing this cycle.
   always_comb begin
      resp_cyc = (state_q == BUSY) && (lat_cnt_q == 3'd0);
      gnt_ok   = rst_n && ((state_q == IDLE) || resp_cyc);
      f_cand   = f_req && !f_flush;
      l_win    = gnt_ok && l_req && (force_l || !f_cand);
      f_win    = gnt_ok && f_cand && !l_win;
   end

   // Next-state and outputs: issue the winner, return the owner's response.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      flushed_d = flushed_q;
      lat_cnt_d = lat_cnt_q;
      f_gnt     = 1'b0;
      l_gnt     = 1'b0;
      f_rvalid  = 1'b0;
      f_rdata   = '0;
      l_rvalid  = 1'b0;
      l_rdata   = '0;
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;

      if (f_win) begin
         f_gnt  = 1'b1;
         m_en   = 1'b1;
         m_addr = f_addr[ADDR_W-1:2];
      end else if (l_win) begin
         l_gnt   = 1'b1;
         m_en    = 1'b1;
         m_we    = l_we;
         m_addr  = l_addr[ADDR_W-1:2];
         m_wdata = l_wdata;
      end

      // A redirect in the response cycle itself also kills the fetch data.
      if (rst_n && resp_cyc) begin
         if (owner_q == OWN_F) begin
            if (!flushed_q && !f_flush) begin
               f_rvalid = 1'b1;
               f_rdata  = m_rdata;
            end
         end else begin
            l_rvalid = 1'b1;
            l_rdata  = we_q ? '0 : m_rdata;
         end
      end

      case (state_q)
         IDLE: begin
            lat_cnt_d = 3'd0;
         end
         BUSY: begin
            if (lat_cnt_q == 3'd0) begin
               state_d   = IDLE;
               flushed_d = 1'b0;
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
               if ((owner_q == OWN_F) && f_flush) begin
                  flushed_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (f_win || l_win) begin
         state_d   = BUSY;
         owner_d   = l_win ? OWN_L : OWN_F;
         we_d      = l_win && l_we;
         flushed_d = 1'b0;
         lat_cnt_d = LAT_LOAD;
      end
   end

   // FSM state register; reset drops any in-flight access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= OWN_F;
         we_q      <= 1'b0;
         flushed_q <= 1'b0;
         lat_cnt_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         flushed_q <= flushed_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_f_gnt_q, perf_f_gnt_d;
   logic [31:0] perf_l_gnt_q, perf_l_gnt_d;
   logic [31:0] perf_l_wait_q, perf_l_wait_d;

   // Saturating event counters.
   always_comb begin
      perf_f_gnt_d  = perf_f_gnt_q;
      perf_l_gnt_d  = perf_l_gnt_q;
      perf_l_wait_d = perf_l_wait_q;
      if (f_win && (perf_f_gnt_q != '1)) perf_f_gnt_d = perf_f_gnt_q + 32'd1;
      if (l_win && (perf_l_gnt_q != '1)) perf_l_gnt_d = perf_l_gnt_q + 32'd1;
      if (l_req && !l_win && (perf_l_wait_q != '1)) perf_l_wait_d = perf_l_wait_q + 32'd1;
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_f_gnt_q  <= '0;
         perf_l_gnt_q  <= '0;
         perf_l_wait_q <= '0;
      end else begin
         perf_f_gnt_q  <= perf_f_gnt_d;
         perf_l_gnt_q  <= perf_l_gnt_d;
         perf_l_wait_q <= perf_l_wait_d;
      end
   end

   assign perf_f_gnt  = perf_f_gnt_q;
   assign perf_l_gnt  = perf_l_gnt_q;
   assign perf_l_wait = perf_l_wait_q;
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench: two arbiters (MEM_LAT=1 and MEM_LAT=3), each with a
// behavioural imem. Expected responses are queued at grant time and retired
// by a per-cycle response checker.
module tb_imem_port_arbiter;
   import imem_arb_pkg::*;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   exp_t qfa[$], qla[$], qfb[$], qlb[$];

   // DUT A (MEM_LAT=1)
   logic        rst_a_n, fa_req, fa_flush, la_req, la_we;
   logic [31:0] fa_addr, la_addr, la_wdata;
   logic        f_gnt_a, f_rvalid_a, l_gnt_a, l_rvalid_a, m_en_a, m_we_a;
   logic [31:0] f_rdata_a, l_rdata_a, m_wdata_a, m_rdata_a;
   logic [29:0] m_addr_a;
   // DUT B (MEM_LAT=3)
   logic        rst_b_n, fb_req, fb_flush, lb_req, lb_we;
   logic [31:0] fb_addr, lb_addr, lb_wdata;
   logic        f_gnt_b, f_rvalid_b, l_gnt_b, l_rvalid_b, m_en_b, m_we_b;
   logic [31:0] f_rdata_b, l_rdata_b, m_wdata_b, m_rdata_b;
   logic [29:0] m_addr_b;
`ifdef IMEM_ARB_PERF_EN
   logic [31:0] pf_a, pl_a, pw_a, unused_pf_b, unused_pl_b, unused_pw_b;
`endif

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] p0_b, p1_b, p2_b;
   bit ev_fa, ev_la, ev_fb, ev_lb;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   imem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(8)) dut_a (
      .clk(clk), .rst_n(rst_a_n),
      .f_req(fa_req), .f_addr(fa_addr), .f_flush(fa_flush),
      .f_gnt(f_gnt_a), .f_rvalid(f_rvalid_a), .f_rdata(f_rdata_a),
      .l_req(la_req), .l_we(la_we), .l_addr(la_addr), .l_wdata(la_wdata),
      .l_gnt(l_gnt_a), .l_rvalid(l_rvalid_a), .l_rdata(l_rdata_a),
      .m_en(m_en_a), .m_we(m_we_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a),
      .m_rdata(m_rdata_a)
`ifdef IMEM_ARB_PERF_EN
      , .perf_f_gnt(pf_a), .perf_l_gnt(pl_a), .perf_l_wait(pw_a)
`endif
   );

   imem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(8)) dut_b (
      .clk(clk), .rst_n(rst_b_n),
      .f_req(fb_req), .f_addr(fb_addr), .f_flush(fb_flush),
      .f_gnt(f_gnt_b), .f_rvalid(f_rvalid_b), .f_rdata(f_rdata_b),
      .l_req(lb_req), .l_we(lb_we), .l_addr(lb_addr), .l_wdata(lb_wdata),
      .l_gnt(l_gnt_b), .l_rvalid(l_rvalid_b), .l_rdata(l_rdata_b),
      .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b),
      .m_rdata(m_rdata_b)
`ifdef IMEM_ARB_PERF_EN
      , .perf_f_gnt(unused_pf_b), .perf_l_gnt(unused_pl_b), .perf_l_wait(unused_pw_b)
`endif
   );

   // Behavioural imems: preload on the first edge, read data MEM_LAT cycles after m_en.
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= NOP;
            mem_b[i] <= NOP;
         end
         mem_a[0] <= 32'h00500093; mem_a[1] <= 32'h00A00113; mem_a[2] <= 32'h002081B3;
         mem_b[0] <= 32'h00500093; mem_b[1] <= 32'h00A00113; mem_b[2] <= 32'h002081B3;
         mem_b[16] <= 32'h12345678;
         m_rdata_a <= 32'hBAD0BAD0;
         p0_b <= 32'hBAD0BAD0; p1_b <= 32'hBAD0BAD0; p2_b <= 32'hBAD0BAD0;
      end else begin
         if (m_en_a) begin
            if (m_we_a) mem_a[m_addr_a[7:0]] <= m_wdata_a;
            m_rdata_a <= mem_a[m_addr_a[7:0]];
         end else begin
            m_rdata_a <= 32'hBAD0BAD0;
         end
         if (m_en_b) begin
            if (m_we_b) mem_b[m_addr_b[7:0]] <= m_wdata_b;
            p0_b <= mem_b[m_addr_b[7:0]];
         end else begin
            p0_b <= 32'hBAD0BAD0;
         end
         p1_b <= p0_b;
         p2_b <= p1_b;
      end
   end
   assign m_rdata_b = p2_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response checker: rvalid/rdata each cycle against the head of each queue.
   always @(negedge clk) begin
      if (cyc > 0) begin
         ev_fa = (qfa.size() > 0) && (qfa[0].due == cyc);
         chk("fa_rvalid", f_rvalid_a, ev_fa);
         chk("fa_rdata", f_rdata_a, ev_fa ? qfa[0].data : 32'h0);
         if (ev_fa) void'(qfa.pop_front());
         ev_la = (qla.size() > 0) && (qla[0].due == cyc);
         chk("la_rvalid", l_rvalid_a, ev_la);
         chk("la_rdata", l_rdata_a, ev_la ? qla[0].data : 32'h0);
         if (ev_la) void'(qla.pop_front());
         ev_fb = (qfb.size() > 0) && (qfb[0].due == cyc);
         chk("fb_rvalid", f_rvalid_b, ev_fb);
         chk("fb_rdata", f_rdata_b, ev_fb ? qfb[0].data : 32'h0);
         if (ev_fb) void'(qfb.pop_front());
         ev_lb = (qlb.size() > 0) && (qlb[0].due == cyc);
         chk("lb_rvalid", l_rvalid_b, ev_lb);
         chk("lb_rdata", l_rdata_b, ev_lb ? qlb[0].data : 32'h0);
         if (ev_lb) void'(qlb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a(input string tag);
      chk({tag, "_f_gnt"}, f_gnt_a, 1'b0);
      chk({tag, "_l_gnt"}, l_gnt_a, 1'b0);
      chk({tag, "_m_en"}, m_en_a, 1'b0);
      chk({tag, "_m_we"}, m_we_a, 1'b0);
      chk({tag, "_m_addr"}, m_addr_a, 30'h0);
      chk({tag, "_m_wdata"}, m_wdata_a, 32'h0);
   endtask

   task automatic idle_b(input string tag);
      chk({tag, "_f_gnt"}, f_gnt_b, 1'b0);
      chk({tag, "_l_gnt"}, l_gnt_b, 1'b0);
      chk({tag, "_m_en"}, m_en_b, 1'b0);
      chk({tag, "_m_we"}, m_we_b, 1'b0);
      chk({tag, "_m_addr"}, m_addr_b, 30'h0);
      chk({tag, "_m_wdata"}, m_wdata_b, 32'h0);
   endtask

   task automatic f_issue_a(input logic [31:0] addr, input logic [31:0] data);
      tick();
      fa_req = 1'b1; fa_addr = addr; la_req = 1'b0;
      #1;
      chk("b2b_f_gnt", f_gnt_a, 1'b1);
      chk("b2b_m_en", m_en_a, 1'b1);
      chk("b2b_m_addr", m_addr_a, addr[31:2]);
      chk("b2b_m_we", m_we_a, 1'b0);
      qfa.push_back('{due: cyc + 1, data: data});
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      fa_req = 1'b1; fa_addr = 32'h0; fa_flush = 1'b0;
      la_req = 1'b1; la_we = 1'b0; la_addr = 32'h40; la_wdata = 32'h0;
      fb_req = 1'b1; fb_addr = 32'h0; fb_flush = 1'b0;
      lb_req = 1'b0; lb_we = 1'b0; lb_addr = 32'h0; lb_wdata = 32'h0;

      // Reset: grants gated while rst_n is low.
      tick(); tick();
      #1;
      chk("rst_gated_f_gnt_a", f_gnt_a, 1'b0);
      chk("rst_gated_l_gnt_a", l_gnt_a, 1'b0);
      chk("rst_gated_m_en_b", m_en_b, 1'b0);
      tick();
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      fa_req = 1'b0; la_req = 1'b0; fb_req = 1'b0;
      #1;
      idle_a("reset_a");
      idle_b("reset_b");

      // A: back-to-back fetches.
      f_issue_a(32'h0, 32'h00500093);
      f_issue_a(32'h4, 32'h00A00113);
      f_issue_a(32'h8, 32'h002081B3);
      tick();
      fa_req = 1'b0;
      #1;
      idle_a("after_b2b");

      // A: loader write then read-back.
      tick();
      la_req = 1'b1; la_we = 1'b1; la_addr = 32'h40; la_wdata = 32'hDEADBEEF;
      #1;
      chk("lw_l_gnt", l_gnt_a, 1'b1);
      chk("lw_f_gnt", f_gnt_a, 1'b0);
      chk("lw_m_we", m_we_a, 1'b1);
      chk("lw_m_addr", m_addr_a, 30'h10);
      chk("lw_m_wdata", m_wdata_a, 32'hDEADBEEF);
      qla.push_back('{due: cyc + 1, data: 32'h0});
      tick();
      la_we = 1'b0;
      #1;
      chk("lr_l_gnt", l_gnt_a, 1'b1);
      chk("lr_m_we", m_we_a, 1'b0);
      chk("lr_m_addr", m_addr_a, 30'h10);
      qla.push_back('{due: cyc + 1, data: 32'hDEADBEEF});
      tick();
      la_req = 1'b0;
      #1;
      idle_a("after_l");

      // A: both requesting continuously -> 8 F grants then 1 L grant, twice.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 9; i++) begin
            tick();
            fa_req = 1'b1; fa_addr = 32'h0; la_req = 1'b1; la_we = 1'b0; la_addr = 32'h40;
            #1;
            if (i < 8) begin
               chk("starve_f_gnt", f_gnt_a, 1'b1);
               chk("starve_l_held", l_gnt_a, 1'b0);
               qfa.push_back('{due: cyc + 1, data: 32'h00500093});
            end else begin
               chk("starve_l_forced", l_gnt_a, 1'b1);
               chk("starve_f_held", f_gnt_a, 1'b0);
               qla.push_back('{due: cyc + 1, data: 32'hDEADBEEF});
            end
         end
      end
      tick();
      fa_req = 1'b0; la_req = 1'b0;
      #1;
      idle_a("after_starve");

      // A: fresh reset, then 5 F grants, 2 L grants, 3 L-wait cycles.
      tick();
      rst_a_n = 1'b0;
      tick();
      rst_a_n = 1'b1;
      #1;
`ifdef IMEM_ARB_PERF_EN
      chk("perf_f_rst", pf_a, 32'd0);
      chk("perf_l_rst", pl_a, 32'd0);
      chk("perf_w_rst", pw_a, 32'd0);
`endif
      for (int i = 0; i < 7; i++) begin
         tick();
         fa_req = (i < 3) || (i >= 5);
         la_req = (i < 5);
         fa_addr = 32'h4; la_addr = 32'h40; la_we = 1'b0;
         #1;
         if (i >= 3 && i < 5) begin
            chk("mix_l_gnt", l_gnt_a, 1'b1);
            qla.push_back('{due: cyc + 1, data: 32'hDEADBEEF});
         end else begin
            chk("mix_f_gnt", f_gnt_a, 1'b1);
            qfa.push_back('{due: cyc + 1, data: 32'h00A00113});
         end
      end
      tick();
      fa_req = 1'b0; la_req = 1'b0;
      #1;
`ifdef IMEM_ARB_PERF_EN
      chk("perf_f_gnt", pf_a, 32'd5);
      chk("perf_l_gnt", pl_a, 32'd2);
      chk("perf_l_wait", pw_a, 32'd3);
`endif

      // B: fetch flushed at T+1 drops its data; fetch granted at T+3 returns at T+6.
      tick();
      fb_req = 1'b1; fb_addr = 32'h4;
      #1;
      chk("fl_f_gnt", f_gnt_b, 1'b1);
      tick();
      fb_req = 1'b0; fb_flush = 1'b1;
      #1;
      chk("fl_busy_f_gnt", f_gnt_b, 1'b0);
      tick();
      fb_flush = 1'b0;
      tick();
      fb_req = 1'b1; fb_addr = 32'h8;
      #1;
      chk("fl_resp_cycle_gnt", f_gnt_b, 1'b1);
      qfb.push_back('{due: cyc + 3, data: 32'h002081B3});
      tick();
      fb_req = 1'b0;
      #1;
      chk("fl_next_f_gnt", f_gnt_b, 1'b0);
      tick(); tick(); tick();
      #1;
      idle_b("after_flush");

      // B: flush in the response cycle itself also suppresses the data.
      tick();
      fb_req = 1'b1; fb_addr = 32'h0;
      #1;
      chk("fl3_f_gnt", f_gnt_b, 1'b1);
      tick();
      fb_req = 1'b0;
      tick(); tick();
      fb_flush = 1'b1;
      tick();
      fb_flush = 1'b0;

      // B: f_req with f_flush never granted; L wins and flush leaves it alone.
      tick();
      fb_req = 1'b1; fb_flush = 1'b1; fb_addr = 32'hC;
      lb_req = 1'b1; lb_we = 1'b0; lb_addr = 32'h40;
      #1;
      chk("flreq_f_gnt", f_gnt_b, 1'b0);
      chk("flreq_l_gnt", l_gnt_b, 1'b1);
      qlb.push_back('{due: cyc + 3, data: 32'h12345678});
      tick();
      fb_req = 1'b0; lb_req = 1'b0;
      #1;
      chk("flreq_next_l_gnt", l_gnt_b, 1'b0);
      tick(); tick(); tick();
      fb_flush = 1'b0;

      // B: reset at T+1 of an L read drops its response; grant on first rst_n=1 cycle.
      tick();
      lb_req = 1'b1; lb_we = 1'b0; lb_addr = 32'h40;
      #1;
      chk("rst_l_gnt", l_gnt_b, 1'b1);
      tick();
      lb_req = 1'b0; rst_b_n = 1'b0;
      tick();
      fb_req = 1'b1; fb_addr = 32'h0;
      #1;
      idle_b("in_reset_b");
      chk("in_reset_l_rvalid", l_rvalid_b, 1'b0);
      tick();
      rst_b_n = 1'b1;
      #1;
      chk("post_rst_f_gnt", f_gnt_b, 1'b1);
      chk("post_rst_m_en", m_en_b, 1'b1);
      qfb.push_back('{due: cyc + 3, data: 32'h00500093});
      tick();
      fb_req = 1'b0;
      tick(); tick(); tick(); tick();

      chk("qfa_drained", qfa.size(), 0);
      chk("qla_drained", qla.size(), 0);
      chk("qfb_drained", qfb.size(), 0);
      chk("qlb_drained", qlb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
